// File: rtl/vec_modsub_ctrl_pkg.sv
// vec_modsub_ctrl_pkg: FSM state encoding and result-buffer depth shared by the vector mod-sub controller
package vec_modsub_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} state_t;
    localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/vec_modsub_ctrl_if.sv
// vec_modsub_ctrl_if: command, operand-read, result-write and status bundle of the vector mod-sub controller
//   command : start, len, q, rd_base, wr_base    (master -> slave)
//   read    : rd_en, rd_addr (slave -> master), rd_a, rd_b (master -> slave, one cycle after rd_en)
//   write   : wr_valid, wr_addr, wr_data (slave -> master), wr_ready (master -> slave)
//   status  : busy, done                          (slave -> master)
interface vec_modsub_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              start;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              busy;
    logic              done;
    modport slave (
        input  start, len, q, rd_base, wr_base, rd_a, rd_b, wr_ready,
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data, busy, done
    );
    modport master (
        output start, len, q, rd_base, wr_base, rd_a, rd_b, wr_ready,
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/vec_modsub_ctrl_mod_sub.sv
// vec_modsub_ctrl_mod_sub: combinational (a - b) mod q for operands already reduced below q
//   i_a, i_b : operands (< i_q)
//   i_q      : modulus
//   o_d      : difference reduced into [0, q)
module vec_modsub_ctrl_mod_sub #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_q,
    output logic [W-1:0] o_d
);
    // a borrow means the raw difference wrapped; adding q in the same modulo-2^W ring fixes it
    assign o_d = (i_a < i_b) ? i_a - i_b + i_q : i_a - i_b;
endmodule

// File: rtl/vec_modsub_ctrl.sv
// vec_modsub_ctrl: streams len elements through (A - B) mod q from operand banks into a result bank
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of vec_modsub_ctrl_if (command, shared operand read, result write, busy/done)
module vec_modsub_ctrl
    import vec_modsub_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input logic           clk,
    input logic           rst_n,
    vec_modsub_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_wr_cnt;
    logic [DATA_W-1:0] r_q;
    logic [ADDR_W-1:0] r_rd_base;
    logic [ADDR_W-1:0] r_res_addr;
    logic              r_infl;
    logic              r_out_v;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_skid_v;
    logic [ADDR_W-1:0] r_skid_addr;
    logic [DATA_W-1:0] r_skid_data;
    logic [DATA_W-1:0] w_res;
    logic              w_hs;
    logic              w_rd_en;
    logic              w_room;
    logic [1:0]        w_occ;
    logic              w_accept;
    logic              w_last_rd;
    logic              w_last_wr;
    vec_modsub_ctrl_mod_sub #(.W(DATA_W)) u_sub (
        .i_a (bus.rd_a),
        .i_b (bus.rd_b),
        .i_q (r_q),
        .o_d (w_res)
    );
    assign w_hs      = r_out_v & bus.wr_ready;
    assign w_accept  = (r_state == ST_IDLE) & bus.start;
    // occupancy counts buffered results plus the read whose data lands this cycle;
    // a handshake this cycle frees one entry in time for a new read
    assign w_occ     = {1'b0, r_out_v} + {1'b0, r_skid_v} + {1'b0, r_infl};
    assign w_room    = w_occ < (2'(BUF_DEPTH) + {1'b0, w_hs});
    assign w_last_rd = w_rd_en & (r_rd_cnt + CNT_ONE == r_len);
    assign w_last_wr = w_hs & (r_wr_cnt + CNT_ONE == r_len);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = bus.start ? ((bus.len == '0) ? ST_FIN : ST_RUN) : ST_IDLE;
            ST_RUN:   w_next = w_last_rd ? ST_DRAIN : ST_RUN;
            ST_DRAIN: w_next = w_last_wr ? ST_FIN : ST_DRAIN;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_comb begin
        w_rd_en      = (r_state == ST_RUN) & w_room;
        bus.rd_en    = w_rd_en;
        bus.rd_addr  = r_rd_base + r_rd_cnt[ADDR_W-1:0];
        bus.wr_valid = r_out_v;
        bus.wr_addr  = r_out_addr;
        bus.wr_data  = r_out_data;
        bus.busy     = (r_state == ST_RUN) | (r_state == ST_DRAIN);
        bus.done     = (r_state == ST_FIN);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_q         <= '0;
            r_rd_base   <= '0;
            r_res_addr  <= '0;
            r_infl      <= 1'b0;
            r_out_v     <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_skid_v    <= 1'b0;
            r_skid_addr <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_accept) begin
                r_len      <= bus.len;
                r_q        <= bus.q;
                r_rd_base  <= bus.rd_base;
                r_res_addr <= bus.wr_base;
                r_rd_cnt   <= '0;
                r_wr_cnt   <= '0;
            end else begin
                if (w_rd_en) r_rd_cnt <= r_rd_cnt + CNT_ONE;
                if (w_hs)    r_wr_cnt <= r_wr_cnt + CNT_ONE;
                if (r_infl)  r_res_addr <= r_res_addr + ADDR_ONE;
            end
            r_infl <= w_rd_en;
            // two-entry FIFO: output register in front, skid register behind it
            if (w_hs) begin
                if (r_skid_v) begin
                    r_out_addr  <= r_skid_addr;
                    r_out_data  <= r_skid_data;
                    r_skid_v    <= r_infl;
                    r_skid_addr <= r_res_addr;
                    r_skid_data <= w_res;
                end else begin
                    r_out_v    <= r_infl;
                    r_out_addr <= r_res_addr;
                    r_out_data <= w_res;
                end
            end else if (r_infl) begin
                if (r_out_v) begin
                    r_skid_v    <= 1'b1;
                    r_skid_addr <= r_res_addr;
                    r_skid_data <= w_res;
                end else begin
                    r_out_v    <= 1'b1;
                    r_out_addr <= r_res_addr;
                    r_out_data <= w_res;
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_modsub_ctrl.sv
// tb_vec_modsub_ctrl: scoreboard bench for vec_modsub_ctrl with directed hand-computed vectors
module tb_vec_modsub_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    initial forever #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;
    int n_chk = 0;
    int n_err = 0;
    vec_modsub_ctrl_if bus ();
    vec_modsub_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    logic [63:0] mem_a [1024];
    logic [63:0] mem_b [1024];
    logic [9:0]  exp_addr [$];
    logic [63:0] exp_data [$];
    logic [9:0]  rd_log [$];
    int          rd_cycs [$];
    int          wr_cycs [$];
    int n_rd = 0;
    int n_wr = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int outst = 0;
    logic       pat_on = 1'b0;
    logic [5:0] pat = 6'b101001;
    int         pi = 0;
    logic        stall = 1'b0;
    logic [9:0]  st_addr;
    logic [63:0] st_data;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_a <= mem_a[bus.rd_addr];
            bus.rd_b <= mem_b[bus.rd_addr];
        end
    end
    always @(posedge clk) begin
        #1;
        if (pat_on) begin
            bus.wr_ready = pat[pi];
            pi = (pi + 1) % 6;
        end else begin
            bus.wr_ready = 1'b1;
        end
    end
    always @(negedge clk) begin
        logic hs;
        if (!rst_n) begin
            outst = 0;
            stall = 1'b0;
        end else begin
            hs = bus.wr_valid & bus.wr_ready;
            if (stall) begin
                chk("stall_valid", 64'(bus.wr_valid), 64'd1);
                chk("stall_addr", 64'(bus.wr_addr), 64'(st_addr));
                chk("stall_data", bus.wr_data, st_data);
            end
            outst = outst + int'(bus.rd_en) - int'(hs);
            if (bus.rd_en) begin
                rd_log.push_back(bus.rd_addr);
                rd_cycs.push_back(cyc);
                n_rd++;
                n_chk++;
                if (outst > 2) begin
                    n_err++;
                    $display("FAIL outstanding: got %0d reads outstanding, required at most 2", outst);
                end
            end
            if (hs) begin
                wr_cycs.push_back(cyc);
                n_wr++;
                if (exp_addr.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, required no write", bus.wr_addr, bus.wr_data);
                end else begin
                    chk("wr_addr", 64'(bus.wr_addr), 64'(exp_addr.pop_front()));
                    chk("wr_data", bus.wr_data, exp_data.pop_front());
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall   = bus.wr_valid & ~bus.wr_ready;
            st_addr = bus.wr_addr;
            st_data = bus.wr_data;
        end
    end
    task automatic push_exp(input logic [9:0] a, input logic [63:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask
    task automatic start_op(input logic [10:0] l, input logic [63:0] qq, input logic [9:0] rb,
                            input logic [9:0] wb, output int k);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len     = l;
        bus.q       = qq;
        bus.rd_base = rb;
        bus.wr_base = wb;
        @(posedge clk);
        #1;
        k           = cyc;
        bus.start   = 1'b0;
        bus.len     = 11'd5;
        bus.q       = '1;
        bus.rd_base = 10'h155;
        bus.wr_base = 10'h2aa;
    endtask
    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!bus.done && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!bus.done) chk("done_timeout", 64'(bus.done), 64'd1);
        @(posedge clk);
        #1;
    endtask
    task automatic clear_logs();
        rd_log.delete();
        rd_cycs.delete();
        wr_cycs.delete();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int k, d0, w0, r0;
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.q       = '0;
        bus.rd_base = '0;
        bus.wr_base = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
        chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", bus.wr_data, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // basic q=17 run with exact cycle timing
        mem_a[0] = 3; mem_a[1] = 5; mem_a[2] = 9;
        mem_b[0] = 5; mem_b[1] = 3; mem_b[2] = 9;
        push_exp(10'd0, 64'd15);
        push_exp(10'd1, 64'd2);
        push_exp(10'd2, 64'd0);
        clear_logs();
        d0 = done_cnt;
        start_op(11'd3, 64'd17, 10'd0, 10'd0, k);
        wait_done(50);
        chk("t1_first_rd_cyc", 64'(rd_cycs[0]), 64'(k));
        chk("t1_nwr", 64'(wr_cycs.size()), 64'd3);
        chk("t1_first_wr_cyc", 64'(wr_cycs[0]), 64'(k + 2));
        chk("t1_last_wr_cyc", 64'(wr_cycs[2]), 64'(k + 4));
        chk("t1_done_cyc", 64'(done_cyc), 64'(k + 5));
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_busy_after", 64'(bus.busy), 64'd0);
        chk("t1_sb_empty", 64'(exp_addr.size()), 64'd0);
        // modulus close to 2^64
        mem_a[10] = 64'd0;                   mem_b[10] = 64'd1;
        mem_a[11] = 64'hFFFF_FFFF_FFFF_FFC4; mem_b[11] = 64'd0;
        push_exp(10'd100, 64'hFFFF_FFFF_FFFF_FFC4);
        push_exp(10'd101, 64'hFFFF_FFFF_FFFF_FFC4);
        clear_logs();
        d0 = done_cnt;
        start_op(11'd2, 64'hFFFF_FFFF_FFFF_FFC5, 10'd10, 10'd100, k);
        wait_done(50);
        chk("t2_nwr", 64'(wr_cycs.size()), 64'd2);
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_sb_empty", 64'(exp_addr.size()), 64'd0);
        // backpressure with wr_ready pattern 1,0,0,1,0,1
        mem_a[20] = 50;  mem_b[20] = 20;
        mem_a[21] = 7;   mem_b[21] = 8;
        mem_a[22] = 900; mem_b[22] = 100;
        mem_a[23] = 0;   mem_b[23] = 1;
        mem_a[24] = 999; mem_b[24] = 998;
        mem_a[25] = 123; mem_b[25] = 123;
        mem_a[26] = 5;   mem_b[26] = 6;
        mem_a[27] = 600; mem_b[27] = 1;
        push_exp(10'd200, 64'd30);
        push_exp(10'd201, 64'd999);
        push_exp(10'd202, 64'd800);
        push_exp(10'd203, 64'd999);
        push_exp(10'd204, 64'd1);
        push_exp(10'd205, 64'd0);
        push_exp(10'd206, 64'd999);
        push_exp(10'd207, 64'd599);
        clear_logs();
        d0 = done_cnt;
        @(negedge clk);
        pi = 0;
        pat_on = 1'b1;
        start_op(11'd8, 64'd1000, 10'd20, 10'd200, k);
        wait_done(200);
        pat_on = 1'b0;
        chk("t3_nwr", 64'(wr_cycs.size()), 64'd8);
        chk("t3_nrd", 64'(rd_log.size()), 64'd8);
        chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t3_sb_empty", 64'(exp_addr.size()), 64'd0);
        // len = 0, then a start during the done cycle
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        w0 = n_wr;
        r0 = n_rd;
        start_op(11'd0, 64'd17, 10'd0, 10'd0, k);
        @(negedge clk);
        chk("t4_done_now", 64'(bus.done), 64'd1);
        chk("t4_busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b1;
        bus.len   = 11'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("t4_fin_start_busy", 64'(bus.busy), 64'd0);
        chk("t4_fin_start_rd_en", 64'(bus.rd_en), 64'd0);
        chk("t4_fin_start_done", 64'(bus.done), 64'd0);
        repeat (4) @(negedge clk);
        chk("t4_nrd", 64'(n_rd - r0), 64'd0);
        chk("t4_nwr", 64'(n_wr - w0), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        // address wrap-around and a start while busy
        mem_a[1022] = 10; mem_b[1022] = 1;
        mem_a[1023] = 20; mem_b[1023] = 1;
        mem_a[0]    = 30; mem_b[0]    = 1;
        mem_a[1]    = 40; mem_b[1]    = 1;
        push_exp(10'd1022, 64'd9);
        push_exp(10'd1023, 64'd19);
        push_exp(10'd0, 64'd29);
        push_exp(10'd1, 64'd39);
        clear_logs();
        d0 = done_cnt;
        start_op(11'd4, 64'd1000, 10'd1022, 10'd1022, k);
        start_op(11'd5, 64'd1000, 10'd500, 10'd600, w0);
        wait_done(50);
        repeat (4) @(negedge clk);
        chk("t5_nrd", 64'(rd_log.size()), 64'd4);
        chk("t5_rd0", 64'(rd_log[0]), 64'd1022);
        chk("t5_rd1", 64'(rd_log[1]), 64'd1023);
        chk("t5_rd2", 64'(rd_log[2]), 64'd0);
        chk("t5_rd3", 64'(rd_log[3]), 64'd1);
        chk("t5_nwr", 64'(wr_cycs.size()), 64'd4);
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t5_sb_empty", 64'(exp_addr.size()), 64'd0);
        // asynchronous reset mid-run, then a fresh run
        for (int i = 0; i < 6; i++) begin
            mem_a[40 + i] = 64'(i + 2);
            mem_b[40 + i] = 64'd1;
            push_exp(10'(300 + i), 64'(i + 1));
        end
        d0 = done_cnt;
        start_op(11'd6, 64'd100, 10'd40, 10'd300, k);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_done", 64'(bus.done), 64'd0);
        chk("t6_rd_en", 64'(bus.rd_en), 64'd0);
        chk("t6_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("t6_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("t6_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("t6_wr_data", bus.wr_data, 64'd0);
        repeat (3) @(negedge clk);
        exp_addr.delete();
        exp_data.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        mem_a[60] = 77; mem_b[60] = 7;
        mem_a[61] = 3;  mem_b[61] = 4;
        push_exp(10'd400, 64'd70);
        push_exp(10'd401, 64'd99);
        clear_logs();
        start_op(11'd2, 64'd100, 10'd60, 10'd400, k);
        wait_done(50);
        chk("t6_nwr", 64'(wr_cycs.size()), 64'd2);
        chk("t6_done_cyc", 64'(done_cyc), 64'(k + 4));
        chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t6_sb_empty", 64'(exp_addr.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
